// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues in-order imem requests, buffers returned words with
// their PCs, and feeds the decoder under stall backpressure and redirect flushes.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] PC_n,
    output logic        instr_valid
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    typedef logic [PW-1:0] ptr_t;

    logic [31:0] fetch_pc_q, fetch_pc_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    ptr_t        fill_q, fill_d;
    ptr_t        drop_cnt_q, drop_cnt_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [31:0] pc_q   [DEPTH];
    logic [31:0] pc_d   [DEPTH];
    logic [31:0] data_q [DEPTH];
    logic [31:0] data_d [DEPTH];

    ptr_t        entries;
    ptr_t        unfilled;
    logic [PW:0] occupancy;
    logic [AW-1:0] hidx, tidx, fidx;
    logic        head_filled;
    logic        accept;
    logic        pop;
    logic        rsp_drop;
    logic        rsp_fill;
    logic        unused_pc_lsbs;

    // Pointers carry one extra wrap bit so a full buffer is distinguishable from empty.
    assign entries   = tail_q - head_q;
    assign unfilled  = tail_q - fill_q;
    assign occupancy = {1'b0, entries} + {1'b0, drop_cnt_q};
    assign hidx      = head_q[AW-1:0];
    assign tidx      = tail_q[AW-1:0];
    assign fidx      = fill_q[AW-1:0];
    assign unused_pc_lsbs = ^redirect_pc[1:0];

    assign head_filled = (entries != '0) && filled_q[hidx];
    assign instr_valid = reset && head_filled;
    assign instr       = instr_valid ? data_q[hidx] : NOP_INSTR;
    assign PC_n        = instr_valid ? pc_q[hidx]   : 32'h0;

    // Slots still owed a response from a flushed stream count against capacity.
    assign imem_req  = reset && !redirect && (occupancy < (PW+1)'(DEPTH));
    assign imem_addr = fetch_pc_q;

    assign accept   = imem_req && imem_gnt;
    assign pop      = instr_valid && !stall;
    assign rsp_drop = imem_rvalid && (drop_cnt_q != '0);
    assign rsp_fill = imem_rvalid && (drop_cnt_q == '0) && (unfilled != '0);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        fill_d     = fill_q;
        drop_cnt_d = drop_cnt_q;
        filled_d   = filled_q;
        pc_d       = pc_q;
        data_d     = data_q;

        if (redirect) begin
            // Every unfilled slot becomes a response to discard, less one arriving now.
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            head_d     = '0;
            tail_d     = '0;
            fill_d     = '0;
            filled_d   = '0;
            drop_cnt_d = drop_cnt_q + unfilled - ptr_t'(rsp_drop || rsp_fill);
        end else begin
            if (accept) begin
                pc_d[tidx]     = fetch_pc_q;
                filled_d[tidx] = 1'b0;
                tail_d         = tail_q + ptr_t'(1);
                fetch_pc_d     = fetch_pc_q + 32'd4;
            end
            if (rsp_drop) begin
                drop_cnt_d = drop_cnt_q - ptr_t'(1);
            end
            if (rsp_fill) begin
                data_d[fidx]   = imem_rdata;
                filled_d[fidx] = 1'b1;
                fill_d         = fill_q + ptr_t'(1);
            end
            if (pop) begin
                head_d = head_q + ptr_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            drop_cnt_q <= '0;
            filled_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fill_q     <= fill_d;
            drop_cnt_q <= drop_cnt_d;
            filled_q   <= filled_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        data_q <= data_d;
    end

    always_ff @(posedge clk) begin
        if (reset && imem_rvalid) begin
            assert (drop_cnt_q != '0 || unfilled != '0)
                else $error("fetch_unit: imem_rvalid with no outstanding request");
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with a request/response memory model and a
// stream-level reference model of the expected fetch and decode-side sequences.
module tb_fetch_unit;

    localparam int          DEPTH     = 4;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] PC_n;
    logic        instr_valid;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .instr      (instr),
        .PC_n       (PC_n),
        .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          ep;
        int          due;
    } rsp_t;

    rsp_t        mq[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_due = 0;
    int          epoch = 0;
    int          occ = 0;
    int          rdy = 0;
    logic [31:0] exp_fpc = RESET_PC;
    logic [31:0] exp_opc = RESET_PC;
    int          first_req = -1;
    int          first_vld = -1;
    int          vld_cnt = 0;
    bit          fired = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    // rdr_mode: 0 none, 1 redirect, 2 redirect+stall only in a cycle carrying a response.
    task automatic step(input bit rst_n, input bit stl, input int rdr_mode,
                        input logic [31:0] rpc, input bit g, input int lat);
        bit rv, rdr, s, exp_req, exp_vld, acc, ret_cur, pop;
        int stale, due;
        @(negedge clk);
        rv  = rst_n && (mq.size() > 0) && (mq[0].due <= cyc);
        rdr = (rdr_mode == 1) || (rdr_mode == 2 && rv);
        s   = stl || (rdr_mode == 2 && rv);
        if (rdr_mode == 2 && rv) fired = 1'b1;
        reset       = rst_n;
        stall       = s;
        redirect    = rdr;
        redirect_pc = rpc;
        imem_gnt    = g;
        imem_rvalid = rv;
        imem_rdata  = rv ? mq[0].addr + 32'h100 : 32'hdead_beef;
        #1;
        if (!rst_n) begin
            chk("rst_req", 32'(imem_req), 32'd0);
            chk("rst_vld", 32'(instr_valid), 32'd0);
            chk("rst_instr", instr, NOP_INSTR);
            chk("rst_pc", PC_n, 32'd0);
            mq.delete();
            last_due = cyc;
            occ = 0;
            rdy = 0;
            epoch++;
            exp_fpc = RESET_PC;
            exp_opc = RESET_PC;
        end else begin
            stale = 0;
            foreach (mq[i]) if (mq[i].ep != epoch) stale++;
            exp_req = !rdr && (occ + stale < DEPTH);
            exp_vld = rdy > 0;
            chk("req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("addr", imem_addr, exp_fpc);
            chk("vld", 32'(instr_valid), 32'(exp_vld));
            if (exp_vld) begin
                chk("pc", PC_n, exp_opc);
                chk("instr", instr, exp_opc + 32'h100);
            end else begin
                chk("nop_instr", instr, NOP_INSTR);
                chk("nop_pc", PC_n, 32'd0);
            end
            if (imem_req && first_req < 0) first_req = cyc;
            if (instr_valid && first_vld < 0) first_vld = cyc;
            if (instr_valid) vld_cnt++;
            acc     = imem_req && g;
            ret_cur = rv && (mq[0].ep == epoch);
            pop     = exp_vld && !s;
            if (rv) void'(mq.pop_front());
            if (acc) begin
                due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                last_due = due;
                mq.push_back('{addr: imem_addr, ep: epoch, due: due});
            end
            if (rdr) begin
                occ = 0;
                rdy = 0;
                epoch++;
                exp_fpc = {rpc[31:2], 2'b00};
                exp_opc = {rpc[31:2], 2'b00};
            end else begin
                occ = occ + int'(acc) - int'(pop);
                rdy = rdy + int'(ret_cur) - int'(pop);
                if (pop) exp_opc = exp_opc + 32'd4;
                if (acc) exp_fpc = exp_fpc + 32'd4;
            end
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] rpc;
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;

        repeat (3) step(0, 0, 0, 32'h0, 1, 1);

        // Zero-wait streaming: first valid two cycles after first request, then one per cycle.
        first_req = -1;
        first_vld = -1;
        vld_cnt   = 0;
        repeat (20) step(1, 0, 0, 32'h0, 1, 1);
        chk("latency", 32'(first_vld - first_req), 32'd2);
        chk("throughput", 32'(vld_cnt), 32'd18);

        repeat (5) step(1, 1, 0, 32'h0, 1, 1);
        chk("stall_full_req", 32'(imem_req), 32'd0);
        repeat (10) step(1, 0, 0, 32'h0, 1, 1);

        // One-cycle reset mid-stream.
        step(0, 0, 0, 32'h0, 1, 1);
        step(1, 0, 0, 32'h0, 0, 1);
        chk("post_rst_vld", 32'(instr_valid), 32'd0);
        chk("post_rst_instr", instr, NOP_INSTR);
        chk("post_rst_addr", imem_addr, RESET_PC);

        // Grant withheld at 0x8 for three cycles.
        step(1, 0, 0, 32'h0, 1, 1);
        step(1, 0, 0, 32'h0, 1, 1);
        repeat (3) begin
            step(1, 0, 0, 32'h0, 0, 1);
            chk("gnt_hold_addr", imem_addr, 32'h8);
        end
        repeat (6) step(1, 0, 0, 32'h0, 1, 1);

        // Slow memory, then redirect to an unaligned target.
        repeat (6) step(1, 0, 0, 32'h0, 1, 3);
        step(1, 0, 1, 32'h203, 1, 3);
        step(1, 0, 0, 32'h0, 1, 1);
        chk("redir_addr", imem_addr, 32'h200);
        chk("redir_vld", 32'(instr_valid), 32'd0);
        repeat (12) step(1, 0, 0, 32'h0, 1, 1);

        // Redirect coinciding with stall and a returning response.
        fired = 1'b0;
        for (int i = 0; i < 20 && !fired; i++) step(1, 0, 2, 32'h400, 1, 2);
        chk("redir_rv_fired", 32'(fired), 32'd1);
        step(1, 0, 0, 32'h0, 1, 1);
        chk("redir_rv_vld", 32'(instr_valid), 32'd0);
        repeat (10) step(1, 0, 0, 32'h0, 1, 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom;
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
            step($urandom_range(0, 199) != 0,
                 $urandom_range(0, 9) < 3,
                 ($urandom_range(0, 29) == 0) ? 1 : 0,
                 rpc,
                 $urandom_range(0, 9) < 7,
                 int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder / ID_EX pipeline register.
- Holds the fetch PC and issues in-order requests to instruction memory with a request/grant handshake and variable response latency.
- Buffers returned words with their PCs in a small in-order buffer.
- Presents instr / PC_n / instr_valid to the decode stage, honouring stall (backpressure) and redirect (branch/jump flush).

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded on reset
DEPTH, 4, buffer entries and max outstanding requests (power of 2, >=2)
NOP_INSTR, 32'h0000_0013, value on instr when instr_valid=0 (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address (= fetch_pc, word aligned)
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  read data valid; responses return in request order
imem_rdata  input  32  instruction word
stall  input  1  decode cannot accept this cycle
redirect  input  1  flush and restart fetch
redirect_pc  input  32  new fetch address; bits[1:0] ignored (forced 0)
instr  output  32  instruction to decoder
PC_n  output  32  PC of instr
instr_valid  output  1  instr/PC_n hold a real instruction

Behaviour:
- Reset (reset=0 at clk edge): fetch_pc=RESET_PC, buffer empty, drop_cnt=0. While reset=0: imem_req=0, instr_valid=0, instr=NOP_INSTR, PC_n=0.
- Buffer entry = {pc[31:0], data[31:0], filled}. Circular; head/tail/fill pointers wrap modulo DEPTH.
- Issue: imem_req = reset & ~redirect & (entries + drop_cnt < DEPTH). Combinational; uses pre-pop occupancy, so a pop in the same cycle does not enable a request.
- Request acceptance (imem_req & imem_gnt):
  - Allocate tail entry with pc=fetch_pc, filled=0.
  - fetch_pc += 4, wrapping at 2^32.
  - imem_addr must hold stable while imem_req=1 and imem_gnt=0.
- Response (imem_rvalid):
  - If drop_cnt>0: discard the data and decrement drop_cnt.
  - Else: write imem_rdata to the oldest unfilled entry and set filled=1.
  - An rvalid with no outstanding request is a protocol error; ignore it (sim assertion).
- Output:
  - instr_valid = head entry filled.
  - instr = head.data and PC_n = head.pc when valid; otherwise NOP_INSTR and 0.
  - Outputs come from registered storage only; no combinational bypass from imem_rdata.
- Pop: instr_valid & ~stall removes the head at the clock edge. While stall=1, instr and PC_n hold stable.
- Latency:
  - Zero-wait memory (gnt=1, rvalid one cycle after accept): request in cycle t, instr_valid in cycle t+2.
  - Sustained throughput is one instruction per cycle with DEPTH>=3.
- Redirect (highest priority, overrides stall and pop):
  - Next cycle: buffer empty, fetch_pc = {redirect_pc[31:2],2'b00}.
  - drop_cnt_next = drop_cnt + unfilled_entries − (imem_rvalid ? 1 : 0).
  - No request is issued in the redirect cycle.
  - instr_valid=0 in the cycle after redirect.
  - A grant arriving in the redirect cycle is impossible because imem_req=0.
- Simultaneous events:
  - Allocate, fill and pop in the same cycle are all legal.
  - Occupancy updates by +alloc −pop.
- Reset mid-operation:
  - Clears everything, including drop_cnt.
  - Responses to pre-reset requests are the memory's responsibility. The bench resets the memory model together with this block.

Test Plan:
- Reset, then zero-wait memory returning rdata = addr+0x100 -> imem_addr 0x0,0x4,0x8...; instr_valid rises 2 cycles after first req; PC_n=0x0/instr=0x100, then PC_n=0x4/instr=0x104 on consecutive cycles.
- stall=1 for 5 cycles while streaming -> instr/PC_n frozen; buffer fills; imem_req=0 at 4 entries; after release, no instruction is skipped or duplicated.
- imem_gnt low 3 cycles with req=1 at addr 0x8 -> imem_addr stays 0x8; fetch_pc advances only on the grant.
- 3-cycle response latency with 3 requests outstanding, then redirect to 0x203 -> all 3 late responses dropped; next imem_addr=0x200; first valid PC_n=0x200 with the correct data.
- Redirect in the same cycle as stall=1 and rvalid=1 -> buffer flushed; that response counted in the drop; no stale instr_valid in the cycle after.
- reset=0 for one cycle mid-stream -> next cycle instr_valid=0, instr=0x00000013, imem_addr=RESET_PC.
